// File: rtl/alu_issue.sv
// MIPS ALU issue stage: decodes one instruction per cycle into an ALU operation
// plus operands, held in a single output register with a valid/ready handshake.
module alu_issue #(
  parameter int ANCHO_BUS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [ANCHO_BUS-1:0] rs_data,
  input  logic [ANCHO_BUS-1:0] rt_data,
  input  logic [15:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           operation,
  output logic [ANCHO_BUS-1:0] data1,
  output logic [ANCHO_BUS-1:0] data2,
  output logic                 illegal,
  output logic [15:0]          issue_count
);

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // in_ready only depends on the output register and out_ready, so a full
  // register can drain and refill on the same edge.

  logic                 valid_q, valid_d;
  logic [3:0]           op_q, op_d;
  logic [ANCHO_BUS-1:0] d1_q, d1_d;
  logic [ANCHO_BUS-1:0] d2_q, d2_d;
  logic                 ill_q, ill_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [3:0]           dec_op;
  logic [ANCHO_BUS-1:0] dec_d2;
  logic                 dec_ill;
  logic [ANCHO_BUS-1:0] imm_zext;
  logic [ANCHO_BUS-1:0] imm_sext;
  logic                 accept;

  assign imm_zext = {{(ANCHO_BUS-16){1'b0}}, imm};
  assign imm_sext = {{(ANCHO_BUS-16){imm[15]}}, imm};

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Anything not matched below falls through as illegal with rt_data as data2.
  always_comb begin
    dec_op  = 4'b1111;
    dec_d2  = rt_data;
    dec_ill = 1'b1;
    case (opcode)
      6'b000000: begin
        dec_ill = 1'b0;
        case (funct)
          6'b100100:            dec_op = 4'b0000;
          6'b100101:            dec_op = 4'b0001;
          6'b100000, 6'b100001: dec_op = 4'b0010;
          6'b100110:            dec_op = 4'b0100;
          6'b100111:            dec_op = 4'b0101;
          6'b100010, 6'b100011: dec_op = 4'b0110;
          6'b101010:            dec_op = 4'b0111;
          default:              dec_ill = 1'b1;
        endcase
      end
      6'b001100: begin dec_op = 4'b0000; dec_d2 = imm_zext; dec_ill = 1'b0; end
      6'b001101: begin dec_op = 4'b0001; dec_d2 = imm_zext; dec_ill = 1'b0; end
      6'b001000, 6'b001001,
      6'b100011, 6'b101011: begin dec_op = 4'b0010; dec_d2 = imm_sext; dec_ill = 1'b0; end
      6'b001110: begin dec_op = 4'b1001; dec_d2 = imm_zext; dec_ill = 1'b0; end
      6'b001010: begin dec_op = 4'b0111; dec_d2 = imm_sext; dec_ill = 1'b0; end
      6'b000100, 6'b000101: begin dec_op = 4'b0110; dec_ill = 1'b0; end
      default: ;
    endcase
  end

  // Flush wins over accept and drain; the payload is held except on accept.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      d1_d    = rs_data;
      d2_d    = dec_d2;
      ill_d   = dec_ill;
      if (!dec_ill && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= 4'b0000;
      d1_q    <= '0;
      d2_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign operation   = op_q;
  assign data1       = d1_q;
  assign data2       = d2_q;
  assign illegal     = ill_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: queue-based reference model checked every cycle, random
// traffic, and directed scenarios with literal expectations.
module tb_alu_issue;
  localparam int W  = 32;
  localparam int EW = 1 + 4 + 2*W;

  logic         clk, rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [5:0]   opcode, funct;
  logic [W-1:0] rs_data, rt_data, data1, data2;
  logic [15:0]  imm, issue_count;
  logic [3:0]   operation;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue #(.ANCHO_BUS(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
    .data1(data1), .data2(data2), .illegal(illegal), .issue_count(issue_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The output register is a queue of at most one instruction {illegal, op, d1, d2}.
  logic [EW-1:0] exp_q[$];
  int unsigned   exp_cnt;

  function automatic logic [EW-1:0] ref_issue(input logic [5:0] opc, input logic [5:0] fn,
                                              input logic [W-1:0] rs, input logic [W-1:0] rt,
                                              input logic [15:0] im);
    logic [3:0]   op;
    logic [W-1:0] d2;
    logic         ill;
    int           sx;
    sx  = int'($signed(im));
    op  = 4'hF;
    d2  = rt;
    ill = 1'b1;
    if (opc == 6'd0) begin
      ill = 1'b0;
      if (fn == 6'h24) op = 4'd0;
      else if (fn == 6'h25) op = 4'd1;
      else if (fn == 6'h20 || fn == 6'h21) op = 4'd2;
      else if (fn == 6'h26) op = 4'd4;
      else if (fn == 6'h27) op = 4'd5;
      else if (fn == 6'h22 || fn == 6'h23) op = 4'd6;
      else if (fn == 6'h2A) op = 4'd7;
      else begin op = 4'hF; ill = 1'b1; end
    end else if (opc == 6'h0C) begin op = 4'd0; d2 = W'(im); ill = 1'b0; end
    else if (opc == 6'h0D) begin op = 4'd1; d2 = W'(im); ill = 1'b0; end
    else if (opc == 6'h08 || opc == 6'h09 || opc == 6'h23 || opc == 6'h2B) begin
      op = 4'd2; d2 = W'(sx); ill = 1'b0;
    end
    else if (opc == 6'h0E) begin op = 4'd9; d2 = W'(im); ill = 1'b0; end
    else if (opc == 6'h0A) begin op = 4'd7; d2 = W'(sx); ill = 1'b0; end
    else if (opc == 6'h04 || opc == 6'h05) begin op = 4'd6; ill = 1'b0; end
    return {ill, op, rs, d2};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      logic          can_take;
      logic [EW-1:0] item;
      can_take = (exp_q.size() == 0) || out_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && can_take) begin
          item = ref_issue(opcode, funct, rs_data, rt_data, imm);
          exp_q.push_back(item);
          if (!item[EW-1]) exp_cnt = (exp_cnt >= 65535) ? 65535 : exp_cnt + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'((exp_q.size() == 0) || out_ready));
      chk("issue_count", 64'(issue_count), 64'(exp_cnt));
      if (exp_q.size() != 0) begin
        chk("illegal", 64'(illegal), 64'(exp_q[0][EW-1]));
        chk("operation", 64'(operation), 64'(exp_q[0][EW-2 -: 4]));
        chk("data1", 64'(data1), 64'(exp_q[0][2*W-1 -: W]));
        chk("data2", 64'(data2), 64'(exp_q[0][W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] opc, input logic [5:0] fn, input logic [W-1:0] rs,
                       input logic [W-1:0] rt, input logic [15:0] im);
    in_valid = 1'b1;
    opcode   = opc;
    funct    = fn;
    rs_data  = rs;
    rt_data  = rt;
    imm      = im;
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_operation"}, 64'(operation), 64'd0);
    chk({tag, "_data1"}, 64'(data1), 64'd0);
    chk({tag, "_data2"}, 64'(data2), 64'd0);
    chk({tag, "_illegal"}, 64'(illegal), 64'd0);
    chk({tag, "_issue_count"}, 64'(issue_count), 64'd0);
  endtask

  logic [5:0] legal_ops [14];
  logic [5:0] legal_fns [10];

  // ---------------- stimulus ----------------
  initial begin
    legal_ops = '{6'h00, 6'h00, 6'h00, 6'h0C, 6'h0D, 6'h08, 6'h09, 6'h0E,
                  6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h00};
    legal_fns = '{6'h24, 6'h25, 6'h20, 6'h21, 6'h26, 6'h27, 6'h22, 6'h23, 6'h2A, 6'h20};
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct = '0; rs_data = '0; rt_data = '0; imm = '0;
    #1 rst = 1'b1;
    #1 chk_reset_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ADD rs=5 rt=7
    @(negedge clk); out_ready = 1'b1; drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
    @(posedge clk); #3;
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_op", 64'(operation), 64'h2);
    chk("add_d1", 64'(data1), 64'd5);
    chk("add_d2", 64'(data2), 64'd7);
    chk("add_cnt", 64'(issue_count), 64'd1);

    // ADDI sign-extends, XORI zero-extends
    @(negedge clk); drive(6'h08, 6'h00, 32'd1, 32'd9, 16'hFFFE);
    @(posedge clk); #3;
    chk("addi_d2", 64'(data2), 64'hFFFF_FFFE);
    chk("addi_op", 64'(operation), 64'h2);
    @(negedge clk); drive(6'h0E, 6'h00, 32'd1, 32'd9, 16'h8001);
    @(posedge clk); #3;
    chk("xori_d2", 64'(data2), 64'h0000_8001);
    chk("xori_op", 64'(operation), 64'h9);

    // ANDI then a 3-cycle stall with ORI pending
    @(negedge clk); drive(6'h0C, 6'h00, 32'hAA, 32'd3, 16'h00F0);
    @(posedge clk); #3;
    chk("andi_op", 64'(operation), 64'h0);
    @(negedge clk); out_ready = 1'b0; drive(6'h0D, 6'h00, 32'hBB, 32'd4, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_op", 64'(operation), 64'h0);
      chk("stall_d1", 64'(data1), 64'hAA);
      chk("stall_d2", 64'(data2), 64'hF0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #3;
    chk("ori_valid", 64'(out_valid), 64'd1);
    chk("ori_op", 64'(operation), 64'h1);
    chk("ori_d1", 64'(data1), 64'hBB);
    chk("ori_d2", 64'(data2), 64'h1234);
    chk("ori_cnt", 64'(issue_count), 64'd5);

    // illegal opcode
    @(negedge clk); drive(6'h3F, 6'h00, 32'd1, 32'h77, 16'h0);
    @(posedge clk); #3;
    chk("ill_op", 64'(operation), 64'hF);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_d2", 64'(data2), 64'h77);
    chk("ill_cnt", 64'(issue_count), 64'd5);

    // flush with a full register and a pending instruction
    @(negedge clk); out_ready = 1'b0; flush = 1'b1; drive(6'h00, 6'h20, 32'd1, 32'd2, 16'h0);
    @(posedge clk); #3;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_illegal", 64'(illegal), 64'd0);
    chk("flush_cnt", 64'(issue_count), 64'd5);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      opcode    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 13)];
      funct     = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 9)];
      rs_data   = $urandom;
      rt_data   = $urandom;
      imm       = 16'($urandom);
    end

    // reset in the middle of a stall discards the held instruction
    @(negedge clk); flush = 1'b0; out_ready = 1'b0; drive(6'h00, 6'h20, 32'd3, 32'd4, 16'h0);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("stall_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #3;
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // saturate the issue counter, then one more
    @(negedge clk); out_ready = 1'b1; drive(6'h00, 6'h21, 32'd1, 32'd1, 16'h0);
    repeat (65535) @(posedge clk);
    #3 chk("sat_reach", 64'(issue_count), 64'hFFFF);
    @(posedge clk); #3;
    chk("sat_hold", 64'(issue_count), 64'hFFFF);
    chk("sat_valid", 64'(out_valid), 64'd1);

    // asynchronous reset mid-cycle
    #1 rst = 1'b1;
    #1 chk_reset_zero("async");
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter ANCHO_BUS, default 32, giving the operand width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1 bit, a synchronous pipeline flush.
REQ-005 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-006 The block SHALL have ports opcode (input, 6) and funct (input, 6), the MIPS instruction fields.
REQ-007 The block SHALL have ports rs_data and rt_data (input, ANCHO_BUS) and imm (input, 16), the operand sources.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-009 The block SHALL have ports operation (output, 4), data1 and data2 (output, ANCHO_BUS), and illegal (output, 1), all registered and driving the ALU.
REQ-010 The block SHALL have port issue_count (output, 16), the count of accepted legal instructions.

Function
REQ-011 The block SHALL drive in_ready = !out_valid || out_ready (combinational, one output register, no bubble when streaming).
REQ-012 The block SHALL accept an instruction on a clock edge where in_valid && in_ready && !flush, loading operation, data1, data2 and illegal and setting out_valid=1; latency is 1 cycle.
REQ-013 The block SHALL clear out_valid on a clock edge where out_valid && out_ready && no new accept occurs.
REQ-014 The block SHALL hold operation, data1, data2 and illegal stable while out_valid && !out_ready (stall).
REQ-015 The block SHALL set data1=rs_data for every instruction.
REQ-016 For R-type instructions (opcode 000000), data2=rt_data, decoded from funct as: 100100 AND->0000; 100101 OR->0001; 100000 or 100001 ADD->0010; 100110 XOR->0100; 100111 NOR->0101; 100010 or 100011 SUB->0110; 101010 SLT->0111.
REQ-017 The block SHALL decode I-type instructions as: 001100 ANDI->0000, zero-ext; 001101 ORI->0001, zero-ext; 001000 or 001001 ADDI->0010, sign-ext; 001110 XORI->1001, zero-ext; 001010 SLTI->0111, sign-ext; 100011 LW or 101011 SW->0010, sign-ext. Extension applies to imm into data2 at ANCHO_BUS.
REQ-018 The block SHALL decode 000100 BEQ and 000101 BNE to 0110 with data2=rt_data.
REQ-019 For any other opcode/funct, the block SHALL issue operation=1111 and illegal=1, with data1/data2 loaded per REQ-015 and data2=rt_data; the instruction is still presented with out_valid=1.
REQ-020 The block SHALL increment issue_count by 1 per accepted legal instruction, saturating at 16'hFFFF; illegal instructions do not count.
REQ-021 On a clock edge where flush=1, the block SHALL clear out_valid and illegal, ignore in_valid, and leave issue_count unchanged; flush has priority over accept and drain.
REQ-022 When a simultaneous drain (out_ready=1) and accept occur, the new instruction SHALL replace the old with out_valid remaining 1.

Reset
REQ-023 While rst=1, the block SHALL immediately and asynchronously force out_valid=0, operation=0000, data1=0, data2=0, illegal=0 and issue_count=0, regardless of clk.
REQ-024 Reset asserted mid-stall SHALL discard the held instruction; the first edge after rst deasserts behaves as an idle cycle with in_ready=1.

Verification
REQ-025 Scenario: ADD (opcode 000000, funct 100000), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, operation=0010, data1=5, data2=7, issue_count=1.
REQ-026 Scenario: ADDI with imm=16'hFFFE, then XORI with imm=16'h8001 -> data2=32'hFFFFFFFE (op 0010), then data2=32'h00008001 (op 1001).
REQ-027 Scenario: ANDI accepted, out_ready=0 for 3 cycles while a new instruction is offered -> in_ready=0 and outputs held unchanged; on out_ready=1, the held ANDI drains and the pending instruction is accepted the same edge.
REQ-028 Scenario: opcode 111111 -> operation=1111, illegal=1, issue_count unchanged.
REQ-029 Scenario: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, nothing accepted.
REQ-030 Scenario: issue_count preloaded to 16'hFFFF by 65535 legal issues, one more legal issue -> issue_count stays 16'hFFFF; then rst pulse mid-cycle -> all outputs 0 immediately.
